// File: rtl/snd_dma_counter_if.sv
// CPU bus bundle for the STE sound DMA register block.
// One-cycle select strobe, byte write data, combinational read data.
interface snd_dma_counter_if;
  logic       bus_sel;
  logic       bus_we;
  logic [4:0] bus_addr;
  logic [7:0] bus_din;
  logic [7:0] bus_dout;

  modport master (
    output bus_sel,
    output bus_we,
    output bus_addr,
    output bus_din,
    input  bus_dout
  );

  modport slave (
    input  bus_sel,
    input  bus_we,
    input  bus_addr,
    input  bus_din,
    output bus_dout
  );
endinterface

// File: rtl/snd_dma_counter.sv
// STE sound DMA frame address block: CPU sound registers plus
// the running 21-bit word address counter and frame sequencing.
module snd_dma_counter (
  input  logic                     clk32,
  input  logic                     reset,
  snd_dma_counter_if.slave         bus,
  input  logic                     word_adv,
  output logic                     sndon,
  output logic                     sfrep,
  output logic [21:1]              snd,
  output logic [21:1]              sft,
  output logic                     active,
  output logic                     frame_end
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [21:1] start_q;
  logic [21:1] end_q;
  logic [21:1] snd_q;
  logic [21:1] snd_d;
  logic [21:1] sft_q;
  logic [21:1] sft_d;
  logic [21:1] nxt;
  logic        sndon_q;
  logic        sndon_d;
  logic        sfrep_q;
  logic        sfrep_d;
  logic        fe_q;
  logic        fe_d;
  logic        wr;
  logic        wr_ctrl;
  logic        wr_clr;

  assign wr      = bus.bus_sel & bus.bus_we;
  assign wr_ctrl = wr & (bus.bus_addr == 5'd0);
  assign wr_clr  = wr_ctrl & ~bus.bus_din[0];
  assign nxt     = snd_q + 21'd1;

  // Shadow start/end: only LOAD or a repeat reload copies them
  always_ff @(posedge clk32) begin
    if (reset) begin
      start_q <= '0;
      end_q   <= '0;
    end else if (wr) begin
      case (bus.bus_addr)
        5'd1: start_q[21:16] <= bus.bus_din[5:0];
        5'd2: start_q[15:8]  <= bus.bus_din;
        5'd3: start_q[7:1]   <= bus.bus_din[7:1];
        5'd7: end_q[21:16]   <= bus.bus_din[5:0];
        5'd8: end_q[15:8]    <= bus.bus_din;
        5'd9: end_q[7:1]     <= bus.bus_din[7:1];
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    snd_d   = snd_q;
    sft_d   = sft_q;
    fe_d    = 1'b0;
    sndon_d = sndon_q;
    sfrep_d = sfrep_q;
    if (wr_ctrl) begin
      sndon_d = bus.bus_din[0];
      sfrep_d = bus.bus_din[1];
    end
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (sndon_q)
          state_d = S_LOAD;
      end
      (state_q == S_LOAD): begin
        if (start_q == end_q) begin
          state_d = S_IDLE;
          sndon_d = 1'b0;
          fe_d    = 1'b1;
        end else begin
          snd_d   = start_q;
          sft_d   = end_q;
          state_d = S_RUN;
        end
      end
      (state_q == S_RUN): begin
        if (!sndon_q) begin
          state_d = S_IDLE;
        end else if (wr_clr) begin
          // a CPU stop outranks a word fetch in the same cycle
          state_d = S_RUN;
        end else if (word_adv) begin
          if (nxt != sft_q) begin
            snd_d = nxt;
          end else if (sfrep_q) begin
            snd_d = start_q;
            sft_d = end_q;
            fe_d  = 1'b1;
          end else begin
            snd_d   = nxt;
            sndon_d = 1'b0;
            fe_d    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      state_q <= S_IDLE;
      snd_q   <= '0;
      sft_q   <= '0;
      sndon_q <= 1'b0;
      sfrep_q <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      snd_q   <= snd_d;
      sft_q   <= sft_d;
      sndon_q <= sndon_d;
      sfrep_q <= sfrep_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    bus.bus_dout = 8'h00;
    case (bus.bus_addr)
      5'd0: bus.bus_dout = {6'd0, sfrep_q, sndon_q};
      5'd1: bus.bus_dout = {2'd0, start_q[21:16]};
      5'd2: bus.bus_dout = start_q[15:8];
      5'd3: bus.bus_dout = {start_q[7:1], 1'b0};
      5'd4: bus.bus_dout = {2'd0, snd_q[21:16]};
      5'd5: bus.bus_dout = snd_q[15:8];
      5'd6: bus.bus_dout = {snd_q[7:1], 1'b0};
      5'd7: bus.bus_dout = {2'd0, end_q[21:16]};
      5'd8: bus.bus_dout = end_q[15:8];
      5'd9: bus.bus_dout = {end_q[7:1], 1'b0};
      default: bus.bus_dout = 8'h00;
    endcase
  end

  assign sndon     = sndon_q;
  assign sfrep     = sfrep_q;
  assign snd       = snd_q;
  assign sft       = sft_q;
  assign active    = (state_q == S_RUN);
  assign frame_end = fe_q;

endmodule

// File: tb/tb_snd_dma_counter.sv
// Directed bench for snd_dma_counter with a byte-address model
// checked every cycle plus literal frame/readback expectations.
module tb_snd_dma_counter;

  logic        clk32;
  logic        reset;
  logic        word_adv;
  logic        sndon;
  logic        sfrep;
  logic [21:1] snd;
  logic [21:1] sft;
  logic        active;
  logic        frame_end;

  snd_dma_counter_if bus ();

  snd_dma_counter dut (
    .clk32     (clk32),
    .reset     (reset),
    .bus       (bus),
    .word_adv  (word_adv),
    .sndon     (sndon),
    .sfrep     (sfrep),
    .snd       (snd),
    .sft       (sft),
    .active    (active),
    .frame_end (frame_end)
  );

  initial clk32 = 1'b0;
  always #5 clk32 = ~clk32;

  int n_chk  = 0;
  int n_fail = 0;
  int fe_cnt = 0;
  bit act_seen = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // model: byte addresses for registers, word units for snd/sft
  int m_start = 0;
  int m_end   = 0;
  int m_snd   = 0;
  int m_sft   = 0;
  bit m_on    = 0;
  bit m_rep   = 0;
  bit m_act   = 0;
  bit m_load  = 0;
  bit m_fe    = 0;

  function automatic int put_byte(input int a, input int idx, input int d);
    int r;
    r = a;
    case (idx)
      0: r = (a % 65536) + (d % 64) * 65536;
      1: r = (a / 65536) * 65536 + d * 256 + (a % 256);
      default: r = (a / 256) * 256 + (d / 2) * 2;
    endcase
    return r;
  endfunction

  function automatic int get_byte(input int a, input int idx);
    int r;
    case (idx)
      0: r = a / 65536;
      1: r = (a / 256) % 256;
      default: r = a % 256;
    endcase
    return r;
  endfunction

  function automatic int m_read(input int ad);
    int r;
    r = 0;
    if (ad == 0) r = m_rep * 2 + m_on;
    else if (ad >= 1 && ad <= 3) r = get_byte(m_start, ad - 1);
    else if (ad >= 4 && ad <= 6) r = get_byte(m_snd * 2, ad - 4);
    else if (ad >= 7 && ad <= 9) r = get_byte(m_end, ad - 7);
    return r;
  endfunction

  always @(posedge clk32) begin
    bit wc;
    bit n_on;
    bit n_rep;
    int n;
    int a;
    int d;
    if (reset) begin
      m_start = 0; m_end = 0; m_snd = 0; m_sft = 0;
      m_on = 0; m_rep = 0; m_act = 0; m_load = 0; m_fe = 0;
    end else begin
      a = int'(bus.bus_addr);
      d = int'(bus.bus_din);
      wc = bus.bus_sel && bus.bus_we && a == 0;
      n_on  = wc ? d[0] : m_on;
      n_rep = wc ? d[1] : m_rep;
      m_fe = 0;
      if (m_act) begin
        if (!m_on) m_act = 0;
        else if (!(wc && !d[0]) && word_adv) begin
          n = (m_snd + 1) % 2097152;
          if (n != m_sft) m_snd = n;
          else begin
            m_fe = 1;
            if (m_rep) begin
              m_snd = m_start / 2;
              m_sft = m_end / 2;
            end else begin
              m_snd = n; n_on = 0; m_act = 0;
            end
          end
        end
      end else if (m_load) begin
        m_load = 0;
        if (m_start == m_end) begin
          m_fe = 1; n_on = 0;
        end else begin
          m_snd = m_start / 2; m_sft = m_end / 2; m_act = 1;
        end
      end else if (m_on) m_load = 1;
      m_on = n_on;
      m_rep = n_rep;
      if (bus.bus_sel && bus.bus_we) begin
        if (a >= 1 && a <= 3) m_start = put_byte(m_start, a - 1, d);
        if (a >= 7 && a <= 9) m_end = put_byte(m_end, a - 7, d);
      end
    end
  end

  always @(negedge clk32) begin
    chk("snd", int'(snd), m_snd);
    chk("sft", int'(sft), m_sft);
    chk("sndon", int'(sndon), int'(m_on));
    chk("sfrep", int'(sfrep), int'(m_rep));
    chk("active", int'(active), int'(m_act));
    chk("frame_end", int'(frame_end), int'(m_fe));
    chk("dout", int'(bus.bus_dout), m_read(int'(bus.bus_addr)));
    if (frame_end) fe_cnt++;
    if (active) act_seen = 1;
  end

  task automatic tick();
    @(posedge clk32);
    #1;
    bus.bus_sel = 1'b0;
    bus.bus_we  = 1'b0;
    word_adv    = 1'b0;
  endtask

  task automatic set_wr(input int a, input int d);
    bus.bus_sel  = 1'b1;
    bus.bus_we   = 1'b1;
    bus.bus_addr = 5'(a);
    bus.bus_din  = 8'(d);
  endtask

  task automatic wr(input int a, input int d);
    set_wr(a, d);
    tick();
  endtask

  task automatic adv();
    word_adv = 1'b1;
    tick();
  endtask

  task automatic rd(input int a, input int exp, input string nm);
    bus.bus_addr = 5'(a);
    #1;
    chk(nm, int'(bus.bus_dout), exp);
  endtask

  initial begin
    reset = 1'b1;
    word_adv = 1'b0;
    bus.bus_sel = 1'b0;
    bus.bus_we = 1'b0;
    bus.bus_addr = 5'd0;
    bus.bus_din = 8'd0;
    tick();
    tick();
    chk("rst_snd", int'(snd), 0);
    chk("rst_active", int'(active), 0);
    reset = 1'b0;
    tick();

    // single frame 0x100..0x104
    wr(1, 8'h00); wr(2, 8'h01); wr(3, 8'h00);
    wr(7, 8'h00); wr(8, 8'h01); wr(9, 8'h04);
    wr(0, 8'h01);
    tick();
    tick();
    chk("t1_active", int'(active), 1);
    chk("t1_snd0", int'(snd), 'h80);
    chk("t1_sft", int'(sft), 'h82);
    adv();
    chk("t1_snd1", int'(snd), 'h81);
    adv();
    chk("t1_fe", int'(frame_end), 1);
    chk("t1_sndon", int'(sndon), 0);
    chk("t1_snd2", int'(snd), 'h82);
    adv();
    adv();
    chk("t1_idle_snd", int'(snd), 'h82);
    chk("t1_idle_act", int'(active), 0);

    // repeat frame, end moved mid-frame
    wr(0, 8'h03);
    tick();
    tick();
    adv();
    wr(9, 8'h08);
    chk("t2_sft_old", int'(sft), 'h82);
    adv();
    chk("t2_reload", int'(snd), 'h80);
    chk("t2_sft_new", int'(sft), 'h84);
    chk("t2_fe", int'(frame_end), 1);
    chk("t2_act", int'(active), 1);
    adv(); adv(); adv();
    chk("t2_snd83", int'(snd), 'h83);
    word_adv = 1'b1;
    set_wr(9, 8'h0C);
    tick();
    chk("t2_sft_race", int'(sft), 'h84);
    chk("t2_snd_race", int'(snd), 'h80);

    // abort concurrent with a fetch
    word_adv = 1'b1;
    set_wr(0, 8'h00);
    tick();
    chk("t3_snd", int'(snd), 'h80);
    chk("t3_fe", int'(frame_end), 0);
    tick();
    chk("t3_idle", int'(active), 0);
    chk("t3_fecnt", fe_cnt, 3);

    // empty frame
    wr(1, 8'h00); wr(2, 8'h20); wr(3, 8'h00);
    wr(7, 8'h00); wr(8, 8'h20); wr(9, 8'h00);
    act_seen = 0;
    wr(0, 8'h03);
    tick();
    tick();
    tick();
    chk("t4_fecnt", fe_cnt, 4);
    chk("t4_sndon", int'(sndon), 0);
    chk("t4_never_act", int'(act_seen), 0);

    // wrap and live count readback
    wr(1, 8'h3F); wr(2, 8'hFF); wr(3, 8'hFE);
    wr(7, 8'h00); wr(8, 8'h00); wr(9, 8'h04);
    wr(0, 8'h01);
    tick();
    tick();
    chk("t5_top", int'(snd), 'h1FFFFF);
    rd(4, 8'h3F, "t5_cnt_hi");
    rd(6, 8'hFE, "t5_cnt_lo");
    adv();
    chk("t5_wrap", int'(snd), 0);
    rd(4, 8'h00, "t5_cnt4");
    rd(5, 8'h00, "t5_cnt5");
    rd(6, 8'h00, "t5_cnt6");
    rd(0, 8'h01, "t5_ctrl");
    wr(0, 8'h00);
    tick();

    // reset mid-run
    wr(1, 8'h00); wr(2, 8'h24); wr(3, 8'h68);
    wr(7, 8'h01); wr(8, 8'h00); wr(9, 8'h00);
    wr(0, 8'h01);
    tick();
    tick();
    chk("t6_snd", int'(snd), 'h1234);
    chk("t6_sft", int'(sft), 'h8000);
    reset = 1'b1;
    tick();
    chk("t6_rst_snd", int'(snd), 0);
    chk("t6_rst_sft", int'(sft), 0);
    chk("t6_rst_on", int'(sndon), 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) rd(i, 0, "t6_reg");
    tick(); tick(); tick();
    chk("t6_stay_idle", int'(active), 0);
    wr(5, 8'hAA);
    wr(12, 8'hFF);
    rd(5, 0, "t6_cnt_ro");
    rd(12, 0, "t6_unmapped");
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
